cordic_nco_front: RTL

//  Phase-accumulator front end for the pipelined CORDIC rotator: generates (x,y,angle) per en'd cycle.

---
 rtl/cordic_nco_front_if.sv | 28 ++
 rtl/cordic_nco_front.sv | 116 +++++++++++
 2 files changed

// File: rtl/cordic_nco_front_if.sv
// Signal bundle between the NCO front end, its control source and the CORDIC rotator inputs.
interface cordic_nco_front_if #(
  parameter int unsigned DW = 10,
  parameter int unsigned AW = 10,
  parameter int unsigned PW = 24
);
  logic          en;
  logic [PW-1:0] fw_in;
  logic          fw_wr;
  logic [AW-1:0] phoff;
  logic [DW-1:0] amp;
  logic          sync_clr;
  logic [DW-1:0] xout;
  logic [DW-1:0] yout;
  logic [AW-1:0] aout;
  logic          vout;
  logic          wrap;

  modport master (
    output en, fw_in, fw_wr, phoff, amp, sync_clr,
    input  xout, yout, aout, vout, wrap
  );

  modport slave (
    input  en, fw_in, fw_wr, phoff, amp, sync_clr,
    output xout, yout, aout, vout, wrap
  );
endinterface

// File: rtl/cordic_nco_front.sv
// Phase-accumulator NCO front end: produces (x, y, angle) for a pipelined CORDIC rotator,
// folding the angle into [-pi/2, pi/2) by a pi pre-rotation (negated x).
module cordic_nco_front #(
  parameter int unsigned DW = 10,
  parameter int unsigned AW = 10,
  parameter int unsigned PW = 24
) (
  input logic               clk,
  input logic               rst_n,
  cordic_nco_front_if.slave bus
);
  localparam logic [DW-1:0] AMP_MIN  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] AMP_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [AW-1:0] MSB_MASK = {1'b1, {(AW-1){1'b0}}};

  logic [PW-1:0] acc;
  logic [PW-1:0] fw_act;
  logic [PW-1:0] fw_pend;
  logic          pend;
  logic          w0;
  logic          w1;
  logic [AW-1:0] ph;
  logic [2:0]    vsr;
  logic [DW-1:0] xout_r;
  logic [DW-1:0] yout_r;
  logic [AW-1:0] aout_r;
  logic          wrap_r;

  logic [PW:0]   sum_c;
  logic          wrap_ev_c;
  logic          load_ok_c;
  logic          fold_c;
  logic [DW-1:0] amp_neg_c;

  // Wrap detection, fw reload permission, fold decision and saturating negate
  always_comb begin
    sum_c     = {1'b0, acc} + {1'b0, fw_act};
    wrap_ev_c = bus.en & ~bus.sync_clr & sum_c[PW];
    // an idle accumulator (fw_act == 0) never wraps, so it may take a new word at once
    load_ok_c = wrap_ev_c | (bus.en & (fw_act == '0));
    fold_c    = ph[AW-1] ^ ph[AW-2];
    amp_neg_c = (bus.amp == AMP_MIN) ? AMP_MAX : DW'(-bus.amp);
  end

  // Stage 0: phase accumulator; sync_clr overrides en and suppresses the wrap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      w0  <= 1'b0;
    end else begin
      if (bus.sync_clr) begin
        acc <= '0;
      end else if (bus.en) begin
        acc <= sum_c[PW-1:0];
      end
      if (bus.en) begin
        w0 <= wrap_ev_c;
      end
    end
  end

  // Frequency word double buffer: active word only changes on a wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_act  <= '0;
      fw_pend <= '0;
      pend    <= 1'b0;
    end else if (bus.fw_wr && load_ok_c) begin
      fw_act  <= bus.fw_in;
      fw_pend <= bus.fw_in;
      pend    <= 1'b0;
    end else if (bus.fw_wr) begin
      fw_pend <= bus.fw_in;
      pend    <= 1'b1;
    end else if (load_ok_c && pend) begin
      fw_act <= fw_pend;
      pend   <= 1'b0;
    end
  end

  // Stage 1: truncate phase and add offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
      w1 <= 1'b0;
    end else if (bus.en) begin
      ph <= acc[PW-1 -: AW] + bus.phoff;
      w1 <= w0;
    end
  end

  // Stage 2: fold into the CORDIC convergence range; wrap is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aout_r <= '0;
      xout_r <= '0;
      yout_r <= '0;
      wrap_r <= 1'b0;
      vsr    <= '0;
    end else if (bus.en) begin
      aout_r <= fold_c ? (ph ^ MSB_MASK) : ph;
      xout_r <= fold_c ? amp_neg_c : bus.amp;
      yout_r <= '0;
      wrap_r <= w1;
      vsr    <= {vsr[1:0], 1'b1};
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign bus.xout = xout_r;
  assign bus.yout = yout_r;
  assign bus.aout = aout_r;
  assign bus.vout = vsr[2];
  assign bus.wrap = wrap_r;
endmodule
